// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic pipeline register with DEPTH stages.
// Each stage has its own valid bit. A stage is ready when it is empty or when
// every stage downstream of it can advance. This lets gaps ("bubbles") close
// while the output is stalled. flush kills every stage's contents on the next
// edge and blocks both handshakes in that same cycle.
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  // Handshake: a word moves across a port on a rising edge only when that
  // port's valid and ready are both high. The producer holds valid and data
  // steady until the transfer happens. Ready may depend on the other side's
  // ready, but never on this side's valid.

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]               occ_q, occ_d;
  logic [DEPTH-1:0]            rdy;
  logic                        in_fire, out_fire;

  // Stage k is ready when some stage at or after k is empty, or the sink takes a word
  always_comb begin : ready_chain
    logic gap;
    gap = 1'b0;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      gap    = gap | ~valid_q[k];
      rdy[k] = gap | out_ready;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state of each stage: ready stages shift in from upstream, stalled stages hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
    // Data contents are don't-care after a flush; only the valid bits matter.
    if (flush) begin
      valid_d = '0;
    end
  end

  // Occupancy tracks the two transfers; a simultaneous push and pop cancel out
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + CW'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - CW'(1);
    end
  end

  // State registers; the asynchronous reset empties the chain immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain. It uses three instances: DEPTH=3/WIDTH=32,
// DEPTH=4/WIDTH=32 and DEPTH=2/WIDTH=8. Inputs are driven on the falling edge,
// and outputs are sampled 1 time unit after driving, well before the next rising edge.
module tb_pipe_reg_chain;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // DEPTH=3, WIDTH=32
  logic        f3, iv3, ir3, ov3, or3;
  logic [31:0] id3, od3;
  logic [1:0]  oc3;
  // DEPTH=4, WIDTH=32
  logic        f4, iv4, ir4, ov4, or4;
  logic [31:0] id4, od4;
  logic [2:0]  oc4;
  // DEPTH=2, WIDTH=8
  logic        f2, iv2, ir2, ov2, or2;
  logic [7:0]  id2, od2;
  logic [1:0]  oc2;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(f3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .occupancy(oc3)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(f4),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .occupancy(oc4)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(f2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .occupancy(oc2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    f3 = 0; iv3 = 0; id3 = '0; or3 = 0;
    f4 = 0; iv4 = 0; id4 = '0; or4 = 0;
    f2 = 0; iv2 = 0; id2 = '0; or2 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov3); end
    checks++; if (od3 !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", od3); end
    checks++; if (oc3 !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", oc3); end
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir3); end
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0 || oc4 !== 3'd0) begin
      failures++; $display("FAIL reset_d4 in_ready=%b out_valid=%b occ=%0d exp 1/0/0", ir4, ov4, oc4);
    end
  endtask

  // Words 1..8 pushed on consecutive cycles with out_ready=1. Sample c is taken
  // at the falling edge after c rising edges. Word w is accepted at edge w-1 and
  // is seen on the output at sample w+2.
  task automatic test_streaming();
    logic [31:0] exp_d;
    int          exp_occ;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      #1;
      if (c <= 3) exp_occ = c;
      else if (c <= 8) exp_occ = 3;
      else exp_occ = 11 - c;
      checks++;
      if (oc3 !== 2'(exp_occ)) begin
        failures++; $display("FAIL stream_occ c=%0d got=%0d exp=%0d", c, oc3, exp_occ);
      end
      checks++;
      if (ov3 !== ((c >= 3 && c <= 10) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL stream_out_valid c=%0d got=%b", c, ov3);
      end
      if (c >= 3 && c <= 10) begin
        exp_d = 32'(c - 2);
        checks++;
        if (od3 !== exp_d) begin
          failures++; $display("FAIL stream_out_data c=%0d got=%h exp=%h", c, od3, exp_d);
        end
      end
      iv3 = (c < 8);
      id3 = 32'(c + 1);
      or3 = 1'b1;
      #1;
      if (c < 8) begin
        checks++;
        if (ir3 !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, ir3); end
      end
    end
    @(negedge clk);
    iv3 = 0; or3 = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC; words[3] = 32'hD;
    or3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv3 = 1'b1; id3 = words[i];
      #1;
      checks++;
      if (ir3 !== 1'b1) begin failures++; $display("FAIL bp_accept_%0d in_ready got=%b exp=1", i, ir3); end
    end
    @(negedge clk);
    iv3 = 1'b1; id3 = words[3];
    #1;
    checks++; if (ir3 !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", ir3); end
    checks++; if (oc3 !== 2'd3) begin failures++; $display("FAIL bp_full_occ got=%0d exp=3", oc3); end
    checks++; if (ov3 !== 1'b1 || od3 !== 32'hA) begin
      failures++; $display("FAIL bp_full_head got=%b/%h exp=1/0000000a", ov3, od3);
    end
    // Stay stalled for one more edge: nothing may move.
    @(negedge clk);
    #1;
    checks++; if (ir3 !== 1'b0 || oc3 !== 2'd3 || od3 !== 32'hA) begin
      failures++; $display("FAIL bp_hold in_ready=%b occ=%0d data=%h exp 0/3/a", ir3, oc3, od3);
    end
    // One cycle of out_ready: A leaves and D enters on the same edge.
    or3 = 1'b1;
    #1;
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", ir3); end
    @(negedge clk);
    iv3 = 1'b0; or3 = 1'b0;
    #1;
    checks++; if (oc3 !== 2'd3) begin failures++; $display("FAIL bp_swap_occ got=%0d exp=3", oc3); end
    checks++; if (od3 !== 32'hB) begin failures++; $display("FAIL bp_swap_head got=%h exp=0000000b", od3); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (ov3 !== 1'b1 || od3 !== words[i]) begin
        failures++; $display("FAIL bp_drain_%0d got=%b/%h exp=1/%h", i, ov3, od3, words[i]);
      end
      or3 = 1'b1;
      @(negedge clk);
      or3 = 1'b0;
      #1;
    end
    checks++; if (ov3 !== 1'b0 || oc3 !== 2'd0) begin
      failures++; $display("FAIL bp_empty out_valid=%b occ=%0d exp 0/0", ov3, oc3);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] exp_q [$];
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    or4 = 1'b0;
    @(negedge clk); iv4 = 1'b1; id4 = 32'h11;
    @(negedge clk); iv4 = 1'b0;
    @(negedge clk);
    @(negedge clk); iv4 = 1'b1; id4 = 32'h22;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL bub_in_ready_22 got=%b exp=1", ir4); end
    @(negedge clk); iv4 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // 0x11 sits in stage 3, and 0x22 has advanced through the gap to stage 2.
    checks++; if (ov4 !== 1'b1 || od4 !== 32'h11) begin
      failures++; $display("FAIL bub_head got=%b/%h exp=1/00000011", ov4, od4);
    end
    checks++; if (oc4 !== 3'd2) begin failures++; $display("FAIL bub_occ2 got=%0d exp=2", oc4); end
    @(negedge clk); iv4 = 1'b1; id4 = 32'h33;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL bub_in_ready_33 got=%b exp=1", ir4); end
    @(negedge clk); id4 = 32'h44;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL bub_in_ready_44 got=%b exp=1", ir4); end
    @(negedge clk); id4 = 32'h55;
    #1;
    checks++; if (ir4 !== 1'b0 || oc4 !== 3'd4) begin
      failures++; $display("FAIL bub_full in_ready=%b occ=%0d exp 0/4", ir4, oc4);
    end
    iv4 = 1'b0;
    while (exp_q.size() > 0) begin
      checks++;
      if (ov4 !== 1'b1 || od4 !== exp_q[0]) begin
        failures++; $display("FAIL bub_drain got=%b/%h exp=1/%h", ov4, od4, exp_q[0]);
      end
      void'(exp_q.pop_front());
      or4 = 1'b1;
      @(negedge clk);
      or4 = 1'b0;
      #1;
    end
    checks++; if (ov4 !== 1'b0 || oc4 !== 3'd0) begin
      failures++; $display("FAIL bub_empty out_valid=%b occ=%0d exp 0/0", ov4, oc4);
    end
  endtask

  task automatic test_flush();
    or3 = 1'b0;
    @(negedge clk); iv3 = 1'b1; id3 = 32'h51;
    @(negedge clk); id3 = 32'h52;
    @(negedge clk); iv3 = 1'b0;
    #1;
    checks++; if (oc3 !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", oc3); end
    @(negedge clk);
    f3 = 1'b1; iv3 = 1'b1; id3 = 32'h53; or3 = 1'b1;
    #1;
    checks++; if (ir3 !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", ir3); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", ov3); end
    @(negedge clk);
    f3 = 1'b0; iv3 = 1'b0;
    #1;
    checks++; if (oc3 !== 2'd0 || ov3 !== 1'b0) begin
      failures++; $display("FAIL flush_post occ=%0d out_valid=%b exp 0/0", oc3, ov3);
    end
    iv3 = 1'b1; id3 = 32'h60;
    #1;
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL flush_next_in_ready got=%b exp=1", ir3); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      iv3 = 1'b0;
      #1;
      checks++;
      if (ov3 !== ((c == 3) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL flush_next_valid c=%0d got=%b", c, ov3);
      end
      if (c == 3) begin
        checks++;
        if (od3 !== 32'h60) begin failures++; $display("FAIL flush_next_data got=%h exp=00000060", od3); end
      end
    end
    or3 = 1'b0;
  endtask

  task automatic test_async_reset();
    or2 = 1'b0;
    @(negedge clk); iv2 = 1'b1; id2 = 8'hC1;
    @(negedge clk); id2 = 8'hC2;
    @(negedge clk); iv2 = 1'b0;
    #1;
    checks++; if (oc2 !== 2'd2 || ov2 !== 1'b1 || od2 !== 8'hC1) begin
      failures++; $display("FAIL ar_full occ=%0d valid=%b data=%h exp 2/1/c1", oc2, ov2, od2);
    end
    #1;
    rst_n = 1'b0;
    #1;
    // Still about 2 time units before the next rising edge.
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", ov2); end
    checks++; if (od2 !== 8'h00) begin failures++; $display("FAIL ar_out_data got=%h exp=00", od2); end
    checks++; if (oc2 !== 2'd0) begin failures++; $display("FAIL ar_occ got=%0d exp=0", oc2); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ir2 !== 1'b1 || ov2 !== 1'b0) begin
      failures++; $display("FAIL ar_after in_ready=%b out_valid=%b exp 1/0", ir2, ov2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic pipeline register: a chain of DEPTH data stages with per-stage valid bits and a valid/ready handshake on both sides. It generalises the single always-enabled 32-bit return register into a stallable, flushable, bubble-collapsing pipeline. It is used between MIPS datapath stages and on return/write-back paths where downstream back-pressure and branch/exception flushes must be honoured.

## Interface

- WIDTH, 32, data width in bits (≥1)
- DEPTH, 1, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of the occupancy output (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all stage contents
- in_valid  input  1  upstream word present on in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  word present on out_data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  downstream data
- occupancy  output  CW  number of valid stages

## Operation

- Stage 0 is the input side and stage DEPTH-1 the output side. Each stage k holds data[k] and valid[k].
- Stage readiness uses combinational bubble collapsing: rdy[DEPTH-1] = !valid[DEPTH-1] || out_ready; rdy[k] = !valid[k] || rdy[k+1].
- in_ready = rdy[0] && !flush.
- out_valid = valid[DEPTH-1] && !flush. out_data = data[DEPTH-1].
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Per clock, when flush=0 and rdy[k]=1:
  - Stage k loads from stage k-1, or from the input for k=0.
  - valid[k] <= valid[k-1], or in_valid for k=0.
  - data[k] <= data[k-1], or in_data for k=0.
- When rdy[k]=0, stage k holds both its data and valid bit.
- Data registers may load when their valid bit is 0. Consumers must qualify data with valid.
- flush=1: all valid[k] <= 0 on the next edge. Neither side transfers in that cycle, because in_ready and out_valid are forced low. Data contents are don't-care.
- occupancy is a registered count equal to popcount(valid) after each edge.
  - It updates by +1, -1 or 0 from the input and output transfers.
  - It is cleared to 0 by flush.
  - It never exceeds DEPTH and never goes below 0.
- Word order is strictly FIFO. No word is duplicated or dropped, except by flush.

## Timing

- Reset (rst_n=0, asynchronous): all valid = 0, all data = 0, occupancy = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, in_ready = 1 (when flush=0).
- Reset deassertion is taken synchronously by the surrounding reset logic. The first transfer can happen on the first edge after rst_n rises.
- Latency when empty: a word accepted at edge N is at stage DEPTH-1 after edge N+DEPTH-1. out_valid is therefore asserted in the cycle following edge N+DEPTH-1, i.e. DEPTH cycles after acceptance. For DEPTH=1, out_valid is seen the cycle after acceptance.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Full (occupancy=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1: in_ready=1. Simultaneous input and output transfer leaves occupancy unchanged.
- Bubble collapse: with out_ready=0 and a gap between valid stages, upstream stages advance into the gap. in_ready stays 1 until all DEPTH stages are valid.
- Simultaneous flush with in_valid/out_ready: flush wins. No transfer occurs and occupancy is 0 after the edge.
- Reset mid-stream discards all contents immediately, without waiting for a clock edge.
- in_ready depends combinationally on out_ready through the chain. This is the one combinational path; no path exists from in_valid to out_valid.

## Test plan

- Reset/idle (WIDTH=32, DEPTH=3): hold rst_n=0, then release.
  - Required: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Latency/streaming (DEPTH=3): present 0x00000001..0x00000008 on consecutive cycles with out_ready=1.
  - Required: 0x00000001 appears with out_valid=1 exactly 3 cycles after its acceptance.
  - Required: the remaining words follow back-to-back in order, and occupancy settles at 3.
- Back-pressure/full (DEPTH=3): out_ready=0, push 0xA, 0xB, 0xC, 0xD.
  - Required: 0xA–0xC are accepted and in_ready=0 while 0xD is offered; occupancy=3.
  - Then raise out_ready for one cycle. Required: 0xA leaves, 0xD is accepted in the same cycle, and occupancy remains 3.
- Bubble collapse (DEPTH=4): insert 0x11, idle for 2 cycles, insert 0x22, then hold out_ready=0.
  - Required: both words are packed in stages 3 and 2, and in_ready=1 until occupancy reaches 4.
  - Then drain. Required order: 0x11, 0x22.
- Flush collisions (DEPTH=3): with occupancy=2, assert flush with in_valid=1 and out_ready=1.
  - Required: in_ready=0 and out_valid=0 in that cycle, occupancy=0 on the next cycle, and no word ever emitted.
  - The next word pushed after the flush appears alone, 3 cycles later.
- Async reset mid-operation (DEPTH=2, WIDTH=8): pull rst_n low between edges while full.
  - Required: out_valid=0, out_data=0x00 and occupancy=0 immediately, before the next clock edge.
